// File: rtl/writeback_stage_q.sv
// Register-file writeback merging the main pipe with a queued long-latency (mul/div) result stream.
// Define WB_STATS_EN to build the stall/defer statistics counters; otherwise they read as zero.
module writeback_stage_q #(
    parameter int DATA_W   = 64,
    parameter int REG_W    = 5,
    parameter int LL_DEPTH = 4,
    parameter int ZERO_REG = 31
) (
    input  logic                        clk,
    input  logic                        resetl,
    input  logic                        RegWrite_WB,
    input  logic                        Mem2Reg_WB,
    input  logic [REG_W-1:0]            RD_WB,
    input  logic [DATA_W-1:0]           ALUout_WB,
    input  logic [DATA_W-1:0]           ReadData_WB,
    input  logic                        ll_valid,
    input  logic [REG_W-1:0]            ll_rd,
    input  logic [DATA_W-1:0]           ll_data,
    output logic                        ll_ready,
    input  logic [REG_W-1:0]            hz_rn,
    input  logic [REG_W-1:0]            hz_rm,
    output logic                        hz_stall,
    output logic                        RegWrite_ID,
    output logic [REG_W-1:0]            RD_ID,
    output logic [DATA_W-1:0]           MemtoRegOut_ID,
    output logic [$clog2(LL_DEPTH):0]   q_count,
    output logic [31:0]                 stall_cnt,
    output logic [31:0]                 defer_cnt
);
    localparam int PW = $clog2(LL_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [REG_W-1:0] ZR      = REG_W'(ZERO_REG);
    localparam logic [CW-1:0]    DEPTH_C = CW'(LL_DEPTH);

    logic [REG_W-1:0]  rd_q   [LL_DEPTH];
    logic [DATA_W-1:0] data_q [LL_DEPTH];
    logic [LL_DEPTH-1:0] vld_q;
    logic [PW-1:0]     head_q, tail_q;
    logic [CW-1:0]     count_q;

    logic main_live, q_empty, pop, bypass, push, hz;

    assign main_live = RegWrite_WB && (RD_WB != ZR);
    assign q_empty   = (count_q == '0);
    assign ll_ready  = resetl && (count_q < DEPTH_C);
    assign pop       = !main_live && !q_empty;
    assign bypass    = !main_live && q_empty && ll_valid && (ll_rd != ZR);
    // A zero-register result is accepted but never stored.
    assign push      = ll_valid && ll_ready && !bypass && (ll_rd != ZR);
    assign q_count   = count_q;

    always_comb begin
        hz = 1'b0;
        for (int i = 0; i < LL_DEPTH; i++) begin
            if (vld_q[i] && (((hz_rn != ZR) && (rd_q[i] == hz_rn)) ||
                             ((hz_rm != ZR) && (rd_q[i] == hz_rm))))
                hz = 1'b1;
        end
    end
    assign hz_stall = hz;

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail_q]   <= ll_rd;
            data_q[tail_q] <= ll_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetl) begin
            RegWrite_ID    <= 1'b0;
            RD_ID          <= '0;
            MemtoRegOut_ID <= '0;
            vld_q          <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
        end else begin
            if (main_live) begin
                RegWrite_ID    <= 1'b1;
                RD_ID          <= RD_WB;
                MemtoRegOut_ID <= Mem2Reg_WB ? ReadData_WB : ALUout_WB;
            end else if (!q_empty) begin
                RegWrite_ID <= vld_q[head_q];
                if (vld_q[head_q]) begin
                    RD_ID          <= rd_q[head_q];
                    MemtoRegOut_ID <= data_q[head_q];
                end
            end else if (bypass) begin
                RegWrite_ID    <= 1'b1;
                RD_ID          <= ll_rd;
                MemtoRegOut_ID <= ll_data;
            end else begin
                RegWrite_ID <= 1'b0;
            end

            // Squash older queued writes to the same register; a push below
            // in the same cycle is younger and must survive, so it comes last.
            for (int i = 0; i < LL_DEPTH; i++) begin
                if (main_live && (rd_q[i] == RD_WB))
                    vld_q[i] <= 1'b0;
            end
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + 1'b1;
            end
            if (push) begin
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

`ifdef WB_STATS_EN
    logic [31:0] stall_q, defer_q;

    always_ff @(posedge clk) begin
        if (!resetl) begin
            stall_q <= '0;
            defer_q <= '0;
        end else begin
            if (ll_valid && !ll_ready && (stall_q != '1))
                stall_q <= stall_q + 32'd1;
            if (main_live && !q_empty && (defer_q != '1))
                defer_q <= defer_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
    assign defer_cnt = defer_q;
`else
    assign stall_cnt = '0;
    assign defer_cnt = '0;
`endif

endmodule

// File: tb/tb_writeback_stage_q.sv
// Scenario bench for writeback_stage_q: expected register-file writes are queued as
// stimulus is driven and compared one cycle later when the registered outputs appear.
module tb_writeback_stage_q;
    logic        clk;
    logic        resetl;
    logic        RegWrite_WB, Mem2Reg_WB;
    logic [4:0]  RD_WB;
    logic [63:0] ALUout_WB, ReadData_WB;
    logic        ll_valid;
    logic [4:0]  ll_rd;
    logic [63:0] ll_data;
    logic        ll_ready;
    logic [4:0]  hz_rn, hz_rm;
    logic        hz_stall;
    logic        RegWrite_ID;
    logic [4:0]  RD_ID;
    logic [63:0] MemtoRegOut_ID;
    logic [2:0]  q_count;
    logic [31:0] stall_cnt, defer_cnt;

    writeback_stage_q dut (
        .clk(clk), .resetl(resetl),
        .RegWrite_WB(RegWrite_WB), .Mem2Reg_WB(Mem2Reg_WB), .RD_WB(RD_WB),
        .ALUout_WB(ALUout_WB), .ReadData_WB(ReadData_WB),
        .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
        .hz_rn(hz_rn), .hz_rm(hz_rm), .hz_stall(hz_stall),
        .RegWrite_ID(RegWrite_ID), .RD_ID(RD_ID), .MemtoRegOut_ID(MemtoRegOut_ID),
        .q_count(q_count), .stall_cnt(stall_cnt), .defer_cnt(defer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic mwe; logic [4:0] mrd; logic m2r; logic [63:0] alu; logic [63:0] rdat;
        logic llv; logic [4:0] llrd; logic [63:0] lld;
        logic ewe; logic [4:0] erd; logic [63:0] edat; logic [2:0] eq; logic erdy;
        logic [4:0] hrn; logic [4:0] hrm; logic ehz;
    } row_t;

    typedef struct { logic we; logic [4:0] rd; logic [63:0] data; } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [4:0]  last_rd;
    logic [63:0] last_data;
    logic [63:0] rf [32];

    always @(negedge clk) if (resetl && RegWrite_ID) rf[RD_ID] <= MemtoRegOut_ID;

    function automatic row_t R(input logic mwe, input logic [4:0] mrd, input logic m2r,
                               input logic [63:0] alu, input logic [63:0] rdat,
                               input logic llv, input logic [4:0] llrd, input logic [63:0] lld,
                               input logic ewe, input logic [4:0] erd, input logic [63:0] edat,
                               input logic [2:0] eq, input logic erdy);
        row_t r;
        r.mwe = mwe; r.mrd = mrd; r.m2r = m2r; r.alu = alu; r.rdat = rdat;
        r.llv = llv; r.llrd = llrd; r.lld = lld;
        r.ewe = ewe; r.erd = erd; r.edat = edat; r.eq = eq; r.erdy = erdy;
        r.hrn = 5'd0; r.hrm = 5'd0; r.ehz = 1'b0;
        return r;
    endfunction

    function automatic row_t H(input row_t r, input logic [4:0] hrn, input logic [4:0] hrm,
                               input logic ehz);
        row_t o;
        o = r; o.hrn = hrn; o.hrm = hrm; o.ehz = ehz;
        return o;
    endfunction

    task automatic drive(input row_t r);
        RegWrite_WB = r.mwe; RD_WB = r.mrd; Mem2Reg_WB = r.m2r;
        ALUout_WB = r.alu; ReadData_WB = r.rdat;
        ll_valid = r.llv; ll_rd = r.llrd; ll_data = r.lld;
        hz_rn = r.hrn; hz_rm = r.hrm;
    endtask

    // Non-writing cycles leave RD_ID/MemtoRegOut_ID at their previous values.
    task automatic expect_wr(input logic we, input logic [4:0] rd, input logic [63:0] d);
        exp_t e;
        if (we) begin
            last_rd = rd;
            last_data = d;
        end
        e.we = we; e.rd = last_rd; e.data = last_data;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [63:0] got [8];
        logic [63:0] want [8];
        resetl = 1'b0;
        RegWrite_WB = 1'b1; RD_WB = 5'd3; Mem2Reg_WB = 1'b0; ALUout_WB = 64'h1234;
        ReadData_WB = 64'h0; ll_valid = 1'b1; ll_rd = 5'd5; ll_data = 64'h77;
        hz_rn = 5'd5; hz_rm = 5'd3;
        tick();
        tick();
        got[0] = 64'(RegWrite_ID);    want[0] = 64'd0;
        got[1] = 64'(RD_ID);          want[1] = 64'd0;
        got[2] = MemtoRegOut_ID;      want[2] = 64'd0;
        got[3] = 64'(q_count);        want[3] = 64'd0;
        got[4] = 64'(ll_ready);       want[4] = 64'd0;
        got[5] = 64'(hz_stall);       want[5] = 64'd0;
        got[6] = 64'(stall_cnt);      want[6] = 64'd0;
        got[7] = 64'(defer_cnt);      want[7] = 64'd0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (got[i] !== want[i])
                $display("FAIL reset[%0d]: got %h want %h", i, got[i], want[i]);
            else
                n_pass++;
        end
        RegWrite_WB = 1'b0; ll_valid = 1'b0; hz_rn = 5'd0; hz_rm = 5'd0;
        resetl = 1'b1;
        #1;
        n_checks++;
        if (ll_ready !== 1'b1) $display("FAIL reset_release ll_ready: got %b want 1", ll_ready);
        else n_pass++;
        last_rd = 5'd0;
        last_data = 64'd0;
    endtask

    task automatic test_main_mux();
        row_t rows[$];
        exp_t e;
        rows.push_back(R(1, 3, 1, 64'hBB, 64'hAA, 0, 0, 0, 1, 3, 64'hAA, 0, 1));
        rows.push_back(R(1, 4, 0, 64'h77, 64'hCC, 0, 0, 0, 1, 4, 64'h77, 0, 1));
        rows.push_back(R(1, 31, 0, 64'h99, 64'h98, 0, 0, 0, 0, 0, 0, 0, 1));
        rows.push_back(R(0, 6, 0, 64'h11, 64'h12, 0, 0, 0, 0, 0, 0, 0, 1));
        rows.push_back(R(1, 0, 1, 64'h5, 64'hDEADBEEF00000001, 0, 0, 0, 1, 0, 64'hDEADBEEF00000001, 0, 1));
        foreach (rows[i]) begin
            drive(rows[i]);
            expect_wr(rows[i].ewe, rows[i].erd, rows[i].edat);
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({RegWrite_ID, RD_ID, MemtoRegOut_ID} !== {e.we, e.rd, e.data})
                $display("FAIL main_mux[%0d]: got we=%b rd=%0d d=%h want we=%b rd=%0d d=%h",
                         i, RegWrite_ID, RD_ID, MemtoRegOut_ID, e.we, e.rd, e.data);
            else n_pass++;
            n_checks++;
            if (q_count !== rows[i].eq)
                $display("FAIL main_mux[%0d] q_count: got %0d want %0d", i, q_count, rows[i].eq);
            else n_pass++;
        end
    endtask

    task automatic test_bypass();
        row_t rows[$];
        exp_t e;
        rows.push_back(R(0, 0, 0, 0, 0, 1, 5, 64'h10, 1, 5, 64'h10, 0, 1));
        rows.push_back(R(0, 0, 0, 0, 0, 1, 31, 64'h20, 0, 0, 0, 0, 1));
        rows.push_back(R(0, 0, 0, 0, 0, 1, 6, 64'h30, 1, 6, 64'h30, 0, 1));
        rows.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        foreach (rows[i]) begin
            drive(rows[i]);
            expect_wr(rows[i].ewe, rows[i].erd, rows[i].edat);
            #1;
            n_checks++;
            if (ll_ready !== rows[i].erdy)
                $display("FAIL bypass[%0d] ll_ready: got %b want %b", i, ll_ready, rows[i].erdy);
            else n_pass++;
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({RegWrite_ID, RD_ID, MemtoRegOut_ID} !== {e.we, e.rd, e.data})
                $display("FAIL bypass[%0d]: got we=%b rd=%0d d=%h want we=%b rd=%0d d=%h",
                         i, RegWrite_ID, RD_ID, MemtoRegOut_ID, e.we, e.rd, e.data);
            else n_pass++;
            n_checks++;
            if (q_count !== rows[i].eq)
                $display("FAIL bypass[%0d] q_count: got %0d want %0d", i, q_count, rows[i].eq);
            else n_pass++;
        end
    endtask

    task automatic test_queue_full();
        row_t rows[$];
        exp_t e;
        for (int k = 0; k < 4; k++)
            rows.push_back(R(1, 5'(1 + k), 0, 64'h201 + 64'(k), 0, 1, 5'(10 + k), 64'h100 + 64'(k),
                             1, 5'(1 + k), 64'h201 + 64'(k), 3'(k + 1), 1));
        rows.push_back(R(1, 5, 0, 64'h205, 0, 1, 14, 64'h104, 1, 5, 64'h205, 4, 0));
        rows.push_back(R(0, 0, 0, 0, 0, 1, 14, 64'h104, 1, 10, 64'h100, 3, 0));
        rows.push_back(R(0, 0, 0, 0, 0, 1, 14, 64'h104, 1, 11, 64'h101, 3, 1));
        rows.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 64'h102, 2, 1));
        rows.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 64'h103, 1, 1));
        rows.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 1, 14, 64'h104, 0, 1));
        foreach (rows[i]) begin
            drive(rows[i]);
            expect_wr(rows[i].ewe, rows[i].erd, rows[i].edat);
            #1;
            n_checks++;
            if (ll_ready !== rows[i].erdy)
                $display("FAIL queue_full[%0d] ll_ready: got %b want %b", i, ll_ready, rows[i].erdy);
            else n_pass++;
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({RegWrite_ID, RD_ID, MemtoRegOut_ID} !== {e.we, e.rd, e.data})
                $display("FAIL queue_full[%0d]: got we=%b rd=%0d d=%h want we=%b rd=%0d d=%h",
                         i, RegWrite_ID, RD_ID, MemtoRegOut_ID, e.we, e.rd, e.data);
            else n_pass++;
            n_checks++;
            if (q_count !== rows[i].eq)
                $display("FAIL queue_full[%0d] q_count: got %0d want %0d", i, q_count, rows[i].eq);
            else n_pass++;
        end
    endtask

    task automatic test_waw();
        row_t rows[$];
        exp_t e;
        rows.push_back(R(1, 1, 0, 64'h301, 0, 1, 7, 64'h77, 1, 1, 64'h301, 1, 1));
        rows.push_back(R(1, 7, 0, 64'h55, 0, 1, 8, 64'h88, 1, 7, 64'h55, 2, 1));
        rows.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        rows.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 64'h88, 0, 1));
        rows.push_back(R(1, 2, 0, 64'h302, 0, 1, 7, 64'h71, 1, 2, 64'h302, 1, 1));
        rows.push_back(R(1, 7, 0, 64'h56, 0, 1, 7, 64'h72, 1, 7, 64'h56, 2, 1));
        rows.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        rows.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 64'h72, 0, 1));
        foreach (rows[i]) begin
            drive(rows[i]);
            expect_wr(rows[i].ewe, rows[i].erd, rows[i].edat);
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({RegWrite_ID, RD_ID, MemtoRegOut_ID} !== {e.we, e.rd, e.data})
                $display("FAIL waw[%0d]: got we=%b rd=%0d d=%h want we=%b rd=%0d d=%h",
                         i, RegWrite_ID, RD_ID, MemtoRegOut_ID, e.we, e.rd, e.data);
            else n_pass++;
            n_checks++;
            if (q_count !== rows[i].eq)
                $display("FAIL waw[%0d] q_count: got %0d want %0d", i, q_count, rows[i].eq);
            else n_pass++;
            if (i == 3) begin
                @(negedge clk);
                n_checks++;
                if (rf[7] !== 64'h55) $display("FAIL waw_reg7: got %h want %h", rf[7], 64'h55);
                else n_pass++;
            end
        end
    endtask

    task automatic test_hazard();
        row_t rows[$];
        exp_t e;
        rows.push_back(H(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 7, 8, 0));
        rows.push_back(H(R(1, 1, 0, 64'h401, 0, 1, 9, 64'h99, 1, 1, 64'h401, 1, 1), 9, 0, 1));
        rows.push_back(H(R(1, 2, 0, 64'h402, 0, 0, 0, 0, 1, 2, 64'h402, 1, 1), 0, 9, 1));
        rows.push_back(H(R(1, 3, 0, 64'h403, 0, 0, 0, 0, 1, 3, 64'h403, 1, 1), 10, 11, 0));
        rows.push_back(H(R(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 64'h99, 0, 1), 9, 0, 0));
        rows.push_back(H(R(1, 2, 0, 64'h404, 0, 1, 31, 64'h31, 1, 2, 64'h404, 0, 1), 0, 31, 0));
        rows.push_back(H(R(1, 1, 0, 64'h405, 0, 1, 12, 64'h12, 1, 1, 64'h405, 1, 1), 12, 0, 1));
        rows.push_back(H(R(1, 12, 0, 64'h412, 0, 0, 0, 0, 1, 12, 64'h412, 1, 1), 0, 12, 0));
        rows.push_back(H(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 12, 12, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            expect_wr(rows[i].ewe, rows[i].erd, rows[i].edat);
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({RegWrite_ID, RD_ID, MemtoRegOut_ID} !== {e.we, e.rd, e.data})
                $display("FAIL hazard[%0d]: got we=%b rd=%0d d=%h want we=%b rd=%0d d=%h",
                         i, RegWrite_ID, RD_ID, MemtoRegOut_ID, e.we, e.rd, e.data);
            else n_pass++;
            n_checks++;
            if (hz_stall !== rows[i].ehz)
                $display("FAIL hazard[%0d] hz_stall: got %b want %b", i, hz_stall, rows[i].ehz);
            else n_pass++;
        end
    endtask

    task automatic test_stats();
        row_t rows[$];
        exp_t e;
        logic [31:0] want_stall, want_defer;
`ifdef WB_STATS_EN
        want_stall = 32'd3;
        want_defer = 32'd6;
`else
        want_stall = 32'd0;
        want_defer = 32'd0;
`endif
        resetl = 1'b0;
        drive(R(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        tick();
        resetl = 1'b1;
        last_rd = 5'd0;
        last_data = 64'd0;
        for (int k = 0; k < 4; k++)
            rows.push_back(R(1, 5'(1 + k), 0, 64'h501 + 64'(k), 0, 1, 5'(20 + k), 64'h601 + 64'(k),
                             1, 5'(1 + k), 64'h501 + 64'(k), 3'(k + 1), 1));
        for (int k = 0; k < 3; k++)
            rows.push_back(R(1, 5'(5 + k), 0, 64'h505 + 64'(k), 0, 1, 24, 64'h624,
                             1, 5'(5 + k), 64'h505 + 64'(k), 4, 0));
        for (int k = 0; k < 4; k++)
            rows.push_back(R(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'(20 + k), 64'h601 + 64'(k),
                             3'(3 - k), (k != 0)));
        foreach (rows[i]) begin
            drive(rows[i]);
            expect_wr(rows[i].ewe, rows[i].erd, rows[i].edat);
            #1;
            n_checks++;
            if (ll_ready !== rows[i].erdy)
                $display("FAIL stats[%0d] ll_ready: got %b want %b", i, ll_ready, rows[i].erdy);
            else n_pass++;
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({RegWrite_ID, RD_ID, MemtoRegOut_ID, q_count} !== {e.we, e.rd, e.data, rows[i].eq})
                $display("FAIL stats[%0d]: got we=%b rd=%0d d=%h q=%0d want we=%b rd=%0d d=%h q=%0d",
                         i, RegWrite_ID, RD_ID, MemtoRegOut_ID, q_count, e.we, e.rd, e.data, rows[i].eq);
            else n_pass++;
            if (i == 6) begin
                n_checks++;
                if (stall_cnt !== want_stall)
                    $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, want_stall);
                else n_pass++;
            end
        end
        n_checks++;
        if ({stall_cnt, defer_cnt} !== {want_stall, want_defer})
            $display("FAIL stats_final: got stall=%0d defer=%0d want stall=%0d defer=%0d",
                     stall_cnt, defer_cnt, want_stall, want_defer);
        else n_pass++;
    endtask

    initial begin
        resetl = 1'b0;
        RegWrite_WB = 1'b0; Mem2Reg_WB = 1'b0; RD_WB = 5'd0;
        ALUout_WB = 64'd0; ReadData_WB = 64'd0;
        ll_valid = 1'b0; ll_rd = 5'd0; ll_data = 64'd0;
        hz_rn = 5'd0; hz_rm = 5'd0;
        last_rd = 5'd0; last_data = 64'd0;
        test_reset();
        test_main_mux();
        test_bypass();
        test_queue_full();
        test_waw();
        test_hazard();
        test_stats();
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
